alu_operand_writeback_stage: RTL and testbench
==============================================

Name: alu_operand_writeback_stage

Overview:
Issue/writeback stage wrapped around the R-type ALU. It holds the 32x32 integer register file and accepts one decoded R-type instruction per handshake. It reads rs1/rs2 into the ALU operand ports, waits for the ALU's registered result, then writes rd back and signals retirement. It sits between the decoder (upstream) and the R-type ALU (downstream), and closes the loop back into the register file.

Parameters:
XLEN, 32, data width of registers and ALU operands
REG_COUNT, 32, number of architectural registers; index width is log2(REG_COUNT)=5

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  decoder presents an instruction
in_ready  output  1  stage can accept an instruction
in_rs1  input  5  source register 1 index
in_rs2  input  5  source register 2 index
in_rd  input  5  destination register index
in_funct3  input  3  R-type subfunction_3
in_funct7  input  7  R-type subfunction_7
alu_subfunction_3  output  3  to ALU subfunction_3
alu_subfunction_7  output  7  to ALU subfunction_7
alu_operand1  output  XLEN  to ALU input_register1_value
alu_operand2  output  XLEN  to ALU input_register2_value
alu_error  input  1  from ALU error (combinational in ALU)
alu_result  input  XLEN  from ALU result_to_write_rd (registered in ALU)
retire_valid  output  1  one-cycle pulse: instruction completed
retire_rd  output  5  rd of retiring instruction
retire_error  output  1  retiring instruction was illegal, no write performed
dbg_addr  input  5  debug read index
dbg_data  output  XLEN  combinational read of register dbg_addr; x0 reads 0

Behaviour:
- Reset is synchronous and active-high, with one clock. While reset is high at a clk edge: state goes to IDLE and all registers x0..x31 are cleared to 0. Latched fields clear to 0; retire_valid, retire_error and retire_rd clear to 0.
- in_ready = (state==IDLE) && !reset.
- FSM states: IDLE, EXECUTE, WRITEBACK.
  - IDLE: on in_valid && in_ready, latch rs1, rs2, rd, funct3 and funct7, then go to EXECUTE. Otherwise stay in IDLE.
  - EXECUTE: alu_operand1 = x[rs1_q] and alu_operand2 = x[rs2_q]; x0 always reads 0. alu_subfunction_3/7 are driven from the latched values. At the clk edge, sample alu_error into err_q and go to WRITEBACK. The ALU captures its result on the same edge.
  - WRITEBACK: alu_result is valid. retire_valid=1, retire_rd=rd_q, retire_error=err_q, all driven combinationally from state and latches. At the clk edge, write x[rd_q]<=alu_result if rd_q!=0 && !err_q, then go to IDLE.
- Latency is 3 cycles from acceptance to the retire pulse. Throughput is 1 instruction per 3 cycles.
- Outside EXECUTE, the ALU subfunction and operand outputs hold their latched/read values, but the ALU result is ignored.
- Writes to x0 are discarded; x0 reads 0 on every read path, including dbg_data.
- If rd equals rs1 or rs2, the old value is read in EXECUTE and the new value is visible from the next instruction onward. No forwarding is needed because issue is serialised.
- If in_valid is asserted outside IDLE, it is ignored; the decoder must hold it until the handshake completes.
- If reset arrives in EXECUTE or WRITEBACK, the instruction is abandoned: no writeback and no retire pulse in the following cycle.
- dbg_data reflects a write starting the cycle after the write edge.

Optional Feature:
ALU_ERROR_TRAP_EN
- Defined: a retiring instruction with err_q=1 sets a sticky trap flag, exposed on an extra output trap (1 bit, reset 0). While trap=1, the FSM stays in IDLE with in_ready=0 until reset.
- Undefined: there is no trap port. An errored instruction retires with retire_error=1 and no write, and the stage continues normally.

Decomposition:
- Shared package/header, extending the existing define header: FSM state encodings IDLE=2'd0, EXECUTE=2'd1, WRITEBACK=2'd2; REG_INDEX_WIDTH=5; the X0 index constant.
- Reuse the existing subfunction and indicator defines; do not duplicate them.
- One sub-module is natural: register_file_2r1w. It has two combinational read ports plus the debug read port, one synchronous write port, x0 hardwired to 0, and synchronous clear on reset.

Test Plan:
- Reset, then read dbg_addr 0..31 -> all read 0; in_ready=1 on the first cycle after reset deasserts.
- Preload x1=5 and x2=7 via ADD (funct3=0, funct7=0) into rd=3 -> retire_valid on cycle 3 after acceptance; dbg x3 = ALU add of 5 and 7 = 12.
- ADD with rd=0 -> retire_valid=1, retire_error=0, x0 still reads 0; no other register changes.
- funct7=7'h01 (illegal) -> retire_error=1 and x[rd] unchanged. With ALU_ERROR_TRAP_EN, trap=1 and in_ready stays 0 for 10 cycles.
- Back-to-back instructions where the second reads the first's rd (x4=x1+x2, then x5=x4+x4) -> x5=24; in_ready is low for exactly 2 cycles between handshakes.
- Assert reset during EXECUTE -> no retire pulse; all registers read 0; the next instruction completes normally.

Source files
------------

// File: rtl/alu_operand_writeback_stage_pkg.sv
// ---------------------------------------------------------------------------
// alu_operand_writeback_stage_pkg
// Shared definitions for the R-type issue/writeback stage: FSM state
// encodings, register index width and the hardwired-zero register index.
// The ALU subfunction/indicator encodings live in the existing ALU defines
// and are deliberately not repeated here.
// ---------------------------------------------------------------------------
package alu_operand_writeback_stage_pkg;

    localparam int unsigned REG_INDEX_WIDTH = 5;

    localparam logic [REG_INDEX_WIDTH-1:0] X0_INDEX = '0;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        EXECUTE   = 2'd1,
        WRITEBACK = 2'd2
    } wb_state_e;

endpackage

// File: rtl/alu_operand_writeback_stage_register_file_2r1w.sv
// ---------------------------------------------------------------------------
// register_file_2r1w
// Integer register file with two combinational operand read ports, one
// combinational debug read port and one synchronous write port. Register x0
// is hardwired to zero on every read path and writes to it are dropped.
// Synchronous active-high reset clears every register.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   rs1_addr / rs1_data  operand read port 1
//   rs2_addr / rs2_data  operand read port 2
//   dbg_addr / dbg_data  debug read port
//   wr_en, wr_addr,      synchronous write port
//   wr_data
// ---------------------------------------------------------------------------
module register_file_2r1w
    import alu_operand_writeback_stage_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned REG_COUNT = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [REG_INDEX_WIDTH-1:0] rs1_addr,
    output logic [XLEN-1:0]            rs1_data,
    input  logic [REG_INDEX_WIDTH-1:0] rs2_addr,
    output logic [XLEN-1:0]            rs2_data,
    input  logic [REG_INDEX_WIDTH-1:0] dbg_addr,
    output logic [XLEN-1:0]            dbg_data,
    input  logic                       wr_en,
    input  logic [REG_INDEX_WIDTH-1:0] wr_addr,
    input  logic [XLEN-1:0]            wr_data
);

    logic [XLEN-1:0] regs [REG_COUNT];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < REG_COUNT; i++) begin
                regs[REG_INDEX_WIDTH'(i)] <= '0;
            end
        end else if (wr_en && (wr_addr != X0_INDEX)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    assign rs1_data = (rs1_addr == X0_INDEX) ? '0 : regs[rs1_addr];
    assign rs2_data = (rs2_addr == X0_INDEX) ? '0 : regs[rs2_addr];
    assign dbg_data = (dbg_addr == X0_INDEX) ? '0 : regs[dbg_addr];

endmodule

// File: rtl/alu_operand_writeback_stage.sv
// ---------------------------------------------------------------------------
// alu_operand_writeback_stage
// Issue/writeback stage around the registered R-type ALU. Accepts one decoded
// R-type instruction per handshake, presents x[rs1]/x[rs2] and the latched
// subfunctions to the ALU, waits for the ALU's registered result and writes
// it to x[rd], pulsing retire_valid for one cycle. One instruction every
// three cycles; issue is serialised so no forwarding is required.
//
// Optional build macro: ALU_ERROR_TRAP_EN adds a sticky `trap` output that
// is set when an errored instruction retires and blocks further issue until
// reset.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   in_valid/in_ready          decoder handshake
//   in_rs1/in_rs2/in_rd        register indices
//   in_funct3/in_funct7        R-type subfunctions
//   alu_subfunction_3/_7       latched subfunctions to the ALU
//   alu_operand1/2             register operands to the ALU
//   alu_error                  combinational ALU illegal-op indicator
//   alu_result                 registered ALU result
//   retire_valid/_rd/_error    one-cycle retirement report
//   dbg_addr/dbg_data          combinational debug register read
//   trap                       sticky error trap (ALU_ERROR_TRAP_EN only)
// ---------------------------------------------------------------------------
module alu_operand_writeback_stage
    import alu_operand_writeback_stage_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned REG_COUNT = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [REG_INDEX_WIDTH-1:0] in_rs1,
    input  logic [REG_INDEX_WIDTH-1:0] in_rs2,
    input  logic [REG_INDEX_WIDTH-1:0] in_rd,
    input  logic [2:0]                 in_funct3,
    input  logic [6:0]                 in_funct7,
    output logic [2:0]                 alu_subfunction_3,
    output logic [6:0]                 alu_subfunction_7,
    output logic [XLEN-1:0]            alu_operand1,
    output logic [XLEN-1:0]            alu_operand2,
    input  logic                       alu_error,
    input  logic [XLEN-1:0]            alu_result,
    output logic                       retire_valid,
    output logic [REG_INDEX_WIDTH-1:0] retire_rd,
    output logic                       retire_error,
    input  logic [REG_INDEX_WIDTH-1:0] dbg_addr,
    output logic [XLEN-1:0]            dbg_data
`ifdef ALU_ERROR_TRAP_EN
    ,
    output logic                       trap
`endif
);

    wb_state_e                  state_q, state_d;
    logic [REG_INDEX_WIDTH-1:0] rs1_q, rs2_q, rd_q;
    logic [2:0]                 funct3_q;
    logic [6:0]                 funct7_q;
    logic                       err_q;
    logic                       accept;
    logic                       issue_blocked;
    logic                       wr_en;

`ifdef ALU_ERROR_TRAP_EN
    logic trap_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            trap_q <= 1'b0;
        end else if ((state_q == WRITEBACK) && err_q) begin
            trap_q <= 1'b1;
        end
    end

    assign trap          = trap_q;
    assign issue_blocked = trap_q;
`else
    assign issue_blocked = 1'b0;
`endif

    assign in_ready = (state_q == IDLE) && !reset && !issue_blocked;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (accept) state_d = EXECUTE;
            EXECUTE:   state_d = WRITEBACK;
            WRITEBACK: state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            rs1_q    <= '0;
            rs2_q    <= '0;
            rd_q     <= '0;
            funct3_q <= '0;
            funct7_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                rs1_q    <= in_rs1;
                rs2_q    <= in_rs2;
                rd_q     <= in_rd;
                funct3_q <= in_funct3;
                funct7_q <= in_funct7;
            end
            // The ALU captures its result on this same edge; its error flag
            // is combinational, so it must be held here for WRITEBACK.
            if (state_q == EXECUTE) begin
                err_q <= alu_error;
            end
        end
    end

    assign alu_subfunction_3 = funct3_q;
    assign alu_subfunction_7 = funct7_q;

    assign retire_valid = (state_q == WRITEBACK);
    assign retire_rd    = retire_valid ? rd_q : '0;
    assign retire_error = retire_valid && err_q;

    // x0 writes are discarded inside the register file.
    assign wr_en = (state_q == WRITEBACK) && !err_q;

    register_file_2r1w #(
        .XLEN      (XLEN),
        .REG_COUNT (REG_COUNT)
    ) u_regfile (
        .clk      (clk),
        .reset    (reset),
        .rs1_addr (rs1_q),
        .rs1_data (alu_operand1),
        .rs2_addr (rs2_q),
        .rs2_data (alu_operand2),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .wr_en    (wr_en),
        .wr_addr  (rd_q),
        .wr_data  (alu_result)
    );

endmodule

// File: tb/tb_alu_operand_writeback_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_operand_writeback_stage
// Directed bench for the issue/writeback stage. A small behavioural R-type
// ALU (registered result, combinational error) closes the loop; an override
// lets the bench load constants into registers through the normal path.
// ---------------------------------------------------------------------------
module tb_alu_operand_writeback_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [2:0]  alu_subfunction_3;
    logic [6:0]  alu_subfunction_7;
    logic [31:0] alu_operand1, alu_operand2;
    logic        alu_error;
    logic [31:0] alu_result;
    logic        retire_valid;
    logic [4:0]  retire_rd;
    logic        retire_error;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;
`ifdef ALU_ERROR_TRAP_EN
    logic        trap;
`endif

    always #5 clk = ~clk;

    alu_operand_writeback_stage #(
        .XLEN      (32),
        .REG_COUNT (32)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_rs1            (in_rs1),
        .in_rs2            (in_rs2),
        .in_rd             (in_rd),
        .in_funct3         (in_funct3),
        .in_funct7         (in_funct7),
        .alu_subfunction_3 (alu_subfunction_3),
        .alu_subfunction_7 (alu_subfunction_7),
        .alu_operand1      (alu_operand1),
        .alu_operand2      (alu_operand2),
        .alu_error         (alu_error),
        .alu_result        (alu_result),
        .retire_valid      (retire_valid),
        .retire_rd         (retire_rd),
        .retire_error      (retire_error),
        .dbg_addr          (dbg_addr),
        .dbg_data          (dbg_data)
`ifdef ALU_ERROR_TRAP_EN
        ,
        .trap              (trap)
`endif
    );

    // ---------------- behavioural ALU ----------------
    logic        alu_ovr;
    logic [31:0] alu_ovr_val;

    function automatic logic [31:0] alu_calc(input logic [31:0] a, input logic [31:0] b,
                                             input logic [2:0] f3, input logic [6:0] f7);
        case (f3)
            3'd0:    return f7[5] ? a - b : a + b;
            3'd1:    return a << b[4:0];
            3'd2:    return {31'd0, $signed(a) < $signed(b)};
            3'd3:    return {31'd0, a < b};
            3'd4:    return a ^ b;
            3'd5:    return f7[5] ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'd6:    return a | b;
            default: return a & b;
        endcase
    endfunction

    assign alu_error = !((alu_subfunction_7 == 7'h00) ||
                         ((alu_subfunction_7 == 7'h20) &&
                          ((alu_subfunction_3 == 3'd0) || (alu_subfunction_3 == 3'd5))));

    always @(posedge clk) begin
        alu_result <= alu_ovr ? alu_ovr_val
                              : alu_calc(alu_operand1, alu_operand2, alu_subfunction_3, alu_subfunction_7);
    end

    // ---------------- checking helpers ----------------
    int n_cmp  = 0;
    int n_fail = 0;
    logic [31:0] model [32];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Whole-file comparison against the bench model, counted as one check.
    task automatic chk_regfile(input string name);
        int bad = 0;
        for (int i = 0; i < 32; i++) begin
            dbg_addr = 5'(i);
            #1;
            if (dbg_data !== model[i]) bad++;
        end
        chk(name, 32'(bad), 32'd0);
        @(negedge clk);
    endtask

    typedef struct {
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        ovr;
        logic [31:0] ovr_val;
        logic [31:0] exp_op1, exp_op2, exp_rd_val;
    } vec_t;

    // Called at a negedge; returns at the negedge where in_ready is next high
    // (or after an 8-cycle bound).
    task automatic do_issue(input vec_t v, output int lat, output int low, output int pulses,
                            output logic [31:0] op1, output logic [31:0] op2,
                            output logic [2:0] f3o, output logic [6:0] f7o,
                            output logic [4:0] rrd, output logic rerr);
        int w = 0;
        lat = -1; low = -1; pulses = 0;
        op1 = 'x; op2 = 'x; f3o = 'x; f7o = 'x; rrd = 'x; rerr = 1'bx;
        alu_ovr = v.ovr; alu_ovr_val = v.ovr_val;
        in_valid = 1'b1; in_rs1 = v.rs1; in_rs2 = v.rs2; in_rd = v.rd;
        in_funct3 = v.f3; in_funct7 = v.f7;
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) begin
                op1 = alu_operand1; op2 = alu_operand2;
                f3o = alu_subfunction_3; f7o = alu_subfunction_7;
            end
            if (retire_valid) begin
                pulses++;
                if (lat < 0) begin
                    lat = k; rrd = retire_rd; rerr = retire_error;
                end
            end
            if (in_ready) begin
                low = k - 1;
                break;
            end
        end
    endtask

    vec_t vecs [11];
    vec_t v;
    int lat, low, pulses, cnt;
    logic [31:0] op1, op2;
    logic [2:0]  f3o;
    logic [6:0]  f7o;
    logic [4:0]  rrd;
    logic        rerr;

    initial begin
        //            rs1   rs2   rd    f3    f7     ovr  ovr_val       op1           op2           rd value
        vecs[0]  = '{5'd0, 5'd0, 5'd1, 3'd0, 7'h00, 1'b1, 32'd5,        32'd0,        32'd0,        32'd5};
        vecs[1]  = '{5'd0, 5'd0, 5'd2, 3'd0, 7'h00, 1'b1, 32'd7,        32'd0,        32'd0,        32'd7};
        vecs[2]  = '{5'd1, 5'd2, 5'd3, 3'd0, 7'h00, 1'b0, 32'd0,        32'd5,        32'd7,        32'd12};
        vecs[3]  = '{5'd1, 5'd2, 5'd0, 3'd0, 7'h00, 1'b0, 32'd0,        32'd5,        32'd7,        32'd0};
        vecs[4]  = '{5'd1, 5'd2, 5'd4, 3'd0, 7'h00, 1'b0, 32'd0,        32'd5,        32'd7,        32'd12};
        vecs[5]  = '{5'd4, 5'd4, 5'd5, 3'd0, 7'h00, 1'b0, 32'd0,        32'd12,       32'd12,       32'd24};
        vecs[6]  = '{5'd2, 5'd1, 5'd6, 3'd0, 7'h20, 1'b0, 32'd0,        32'd7,        32'd5,        32'd2};
        vecs[7]  = '{5'd1, 5'd2, 5'd7, 3'd4, 7'h00, 1'b0, 32'd0,        32'd5,        32'd7,        32'd2};
        vecs[8]  = '{5'd5, 5'd1, 5'd8, 3'd1, 7'h00, 1'b0, 32'd0,        32'd24,       32'd5,        32'd768};
        vecs[9]  = '{5'd1, 5'd2, 5'd1, 3'd0, 7'h20, 1'b0, 32'd0,        32'd5,        32'd7,        32'hFFFF_FFFE};
        vecs[10] = '{5'd1, 5'd1, 5'd9, 3'd0, 7'h00, 1'b0, 32'd0,        32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFC};

        for (int i = 0; i < 32; i++) model[i] = '0;
        reset = 1'b1; in_valid = 1'b0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
        in_funct3 = '0; in_funct7 = '0; dbg_addr = '0; alu_ovr = 1'b0; alu_ovr_val = '0;

        // ---- reset ----
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("ready_in_reset", 32'(in_ready), 32'd0);
        reset = 1'b0;
        #1;
        chk("ready_after_reset", 32'(in_ready), 32'd1);
        chk("retire_valid_reset", 32'(retire_valid), 32'd0);
        chk("retire_rd_reset", 32'(retire_rd), 32'd0);
        chk("retire_error_reset", 32'(retire_error), 32'd0);
`ifdef ALU_ERROR_TRAP_EN
        chk("trap_reset", 32'(trap), 32'd0);
`endif
        for (int i = 0; i < 32; i++) begin
            dbg_addr = 5'(i);
            #1;
            chk($sformatf("reset_x%0d", i), dbg_data, 32'd0);
        end
        @(negedge clk);

        // ---- table-driven instructions ----
        for (int i = 0; i < 11; i++) begin
            do_issue(vecs[i], lat, low, pulses, op1, op2, f3o, f7o, rrd, rerr);
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'd2);
            chk($sformatf("v%0d_ready_low", i), 32'(low), 32'd2);
            chk($sformatf("v%0d_pulses", i), 32'(pulses), 32'd1);
            chk($sformatf("v%0d_op1", i), op1, vecs[i].exp_op1);
            chk($sformatf("v%0d_op2", i), op2, vecs[i].exp_op2);
            chk($sformatf("v%0d_f3", i), 32'(f3o), 32'(vecs[i].f3));
            chk($sformatf("v%0d_f7", i), 32'(f7o), 32'(vecs[i].f7));
            chk($sformatf("v%0d_retire_rd", i), 32'(rrd), 32'(vecs[i].rd));
            chk($sformatf("v%0d_retire_err", i), 32'(rerr), 32'd0);
            if (vecs[i].rd != 5'd0) model[vecs[i].rd] = vecs[i].exp_rd_val;
            dbg_addr = vecs[i].rd;
            #1;
            chk($sformatf("v%0d_dbg_rd", i), dbg_data, vecs[i].exp_rd_val);
            chk_regfile($sformatf("v%0d_regfile", i));
        end

        // ---- illegal funct7: error retire, no write ----
        v = '{5'd1, 5'd2, 5'd3, 3'd0, 7'h01, 1'b1, 32'hDEAD_BEEF, 32'd0, 32'd0, 32'd0};
        do_issue(v, lat, low, pulses, op1, op2, f3o, f7o, rrd, rerr);
        chk("illegal_latency", 32'(lat), 32'd2);
        chk("illegal_retire_err", 32'(rerr), 32'd1);
        chk("illegal_retire_rd", 32'(rrd), 32'd3);
        chk_regfile("illegal_regfile");
`ifdef ALU_ERROR_TRAP_EN
        chk("trap_set", 32'(trap), 32'd1);
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (in_ready) cnt++;
        end
        chk("trap_ready_low", 32'(cnt), 32'd0);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("trap_cleared", 32'(trap), 32'd0);
        for (int i = 0; i < 32; i++) model[i] = '0;
        @(negedge clk);
`else
        v = '{5'd2, 5'd2, 5'd10, 3'd0, 7'h00, 1'b0, 32'd0, 32'd7, 32'd7, 32'd14};
        do_issue(v, lat, low, pulses, op1, op2, f3o, f7o, rrd, rerr);
        chk("post_err_latency", 32'(lat), 32'd2);
        chk("post_err_retire_err", 32'(rerr), 32'd0);
        model[10] = 32'd14;
        chk_regfile("post_err_regfile");
`endif

        // ---- reset during EXECUTE abandons the instruction ----
        alu_ovr = 1'b1; alu_ovr_val = 32'h1234_5678;
        in_valid = 1'b1; in_rs1 = 5'd2; in_rs2 = 5'd2; in_rd = 5'd11;
        in_funct3 = 3'd0; in_funct7 = 7'h00;
        cnt = 0;
        while (!in_ready && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        chk("abort_accept", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_ready_in_reset", 32'(in_ready), 32'd0);
        cnt = 0;
        if (retire_valid) cnt++;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1 if (retire_valid) cnt++;
            @(negedge clk);
        end
        chk("abort_no_retire", 32'(cnt), 32'd0);
        for (int i = 0; i < 32; i++) model[i] = '0;
        chk_regfile("abort_regfile");

        v = '{5'd0, 5'd0, 5'd1, 3'd0, 7'h00, 1'b1, 32'd9, 32'd0, 32'd0, 32'd9};
        do_issue(v, lat, low, pulses, op1, op2, f3o, f7o, rrd, rerr);
        chk("after_abort_latency", 32'(lat), 32'd2);
        v = '{5'd1, 5'd1, 5'd2, 3'd0, 7'h00, 1'b0, 32'd0, 32'd9, 32'd9, 32'd18};
        do_issue(v, lat, low, pulses, op1, op2, f3o, f7o, rrd, rerr);
        chk("after_abort_op1", op1, 32'd9);
        model[1] = 32'd9;
        model[2] = 32'd18;
        chk_regfile("after_abort_regfile");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1);
    end

endmodule
